// File: rtl/cd_sector_buffer.sv
// Captures one raw CD sector from HPS into local RAM, then replays it to the core at a fixed
// word pace so HPS burst timing never reaches the CDIC. Flags short and overlong HPS transfers.
module cd_sector_buffer #(
    parameter int unsigned WORDS_PER_SECTOR = 1176,
    parameter int unsigned PACE_CYCLES      = 8,
    parameter int unsigned TIMEOUT_CYCLES   = 1_000_000
) (
    input  logic        clk30,
    input  logic        reset_n,
    input  logic [31:0] core_lba,
    input  logic        core_req,
    output logic        core_ack,
    output logic        core_data_valid,
    output logic [15:0] core_data,
    output logic [31:0] hps_lba,
    output logic        hps_req,
    input  logic        hps_ack,
    input  logic        hps_data_valid,
    input  logic [15:0] hps_data,
    output logic        busy,
    output logic        fail_short,
    output logic        fail_overrun
);
    localparam int unsigned CW = $clog2(WORDS_PER_SECTOR + 1);
    localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PW = $clog2(PACE_CYCLES);

    localparam logic [CW-1:0] LastWord   = CW'(WORDS_PER_SECTOR - 1);
    localparam logic [CW-1:0] NumWords   = CW'(WORDS_PER_SECTOR);
    localparam logic [IW-1:0] TimeoutVal = IW'(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] PaceLast   = PW'(PACE_CYCLES - 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StReq     = 3'd1;
    localparam logic [2:0] StWaitAck = 3'd2;
    localparam logic [2:0] StFill    = 3'd3;
    localparam logic [2:0] StDrain   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [31:0]   hps_lba_q, hps_lba_d;
    logic          pend_q, pend_d;
    logic [31:0]   pend_lba_q, pend_lba_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [PW-1:0] pace_q, pace_d;
    logic          core_ack_q, core_ack_d;
    logic          valid_q, valid_d;
    logic          data_en_q, data_en_d;
    logic          fail_short_q, fail_short_d;
    logic          fail_overrun_q, fail_overrun_d;
    logic          ram_we;

    logic [15:0]   mem [WORDS_PER_SECTOR];
    logic [15:0]   rdata_q;

    always_comb begin
        state_d        = state_q;
        hps_lba_d      = hps_lba_q;
        pend_d         = pend_q;
        pend_lba_d     = pend_lba_q;
        wr_cnt_d       = wr_cnt_q;
        rd_cnt_d       = rd_cnt_q;
        idle_d         = idle_q;
        pace_d         = pace_q;
        core_ack_d     = 1'b0;
        valid_d        = 1'b0;
        data_en_d      = 1'b0;
        fail_short_d   = fail_short_q;
        fail_overrun_d = fail_overrun_q;
        ram_we         = 1'b0;

        if (hps_data_valid && state_q != StFill) begin
            fail_overrun_d = 1'b1;
        end
        if (core_req && state_q != StIdle && !pend_q) begin
            pend_d     = 1'b1;
            pend_lba_d = core_lba;
        end

        case (state_q)
            StIdle: begin
                if (pend_q) begin
                    // A request arriving as the pending one is served becomes the new pending one.
                    hps_lba_d  = pend_lba_q;
                    pend_d     = core_req;
                    pend_lba_d = core_lba;
                    state_d    = StReq;
                end else if (core_req) begin
                    hps_lba_d = core_lba;
                    state_d   = StReq;
                end
            end
            StReq: state_d = StWaitAck;
            StWaitAck: begin
                if (hps_ack) begin
                    wr_cnt_d = '0;
                    idle_d   = '0;
                    state_d  = StFill;
                end
            end
            StFill: begin
                if (hps_data_valid) begin
                    ram_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + CW'(1);
                    idle_d   = '0;
                    if (wr_cnt_q == LastWord) begin
                        core_ack_d = 1'b1;
                        rd_cnt_d   = '0;
                        pace_d     = '0;
                        state_d    = StDrain;
                    end
                end else begin
                    idle_d = idle_q + IW'(1);
                    if (idle_d == TimeoutVal) begin
                        fail_short_d = 1'b1;
                        core_ack_d   = 1'b1;
                        rd_cnt_d     = '0;
                        pace_d       = '0;
                        state_d      = StDrain;
                    end
                end
            end
            StDrain: begin
                // wr_cnt_q stays frozen here and serves as the fill count.
                if (valid_q && rd_cnt_q == NumWords) begin
                    state_d = StIdle;
                end else if (rd_cnt_q != NumWords) begin
                    if (pace_q == PaceLast) begin
                        pace_d    = '0;
                        valid_d   = 1'b1;
                        data_en_d = (rd_cnt_q < wr_cnt_q);
                        rd_cnt_d  = rd_cnt_q + CW'(1);
                    end else begin
                        pace_d = pace_q + PW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk30 or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            hps_lba_q      <= '0;
            pend_q         <= 1'b0;
            pend_lba_q     <= '0;
            wr_cnt_q       <= '0;
            rd_cnt_q       <= '0;
            idle_q         <= '0;
            pace_q         <= '0;
            core_ack_q     <= 1'b0;
            valid_q        <= 1'b0;
            data_en_q      <= 1'b0;
            fail_short_q   <= 1'b0;
            fail_overrun_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hps_lba_q      <= hps_lba_d;
            pend_q         <= pend_d;
            pend_lba_q     <= pend_lba_d;
            wr_cnt_q       <= wr_cnt_d;
            rd_cnt_q       <= rd_cnt_d;
            idle_q         <= idle_d;
            pace_q         <= pace_d;
            core_ack_q     <= core_ack_d;
            valid_q        <= valid_d;
            data_en_q      <= data_en_d;
            fail_short_q   <= fail_short_d;
            fail_overrun_q <= fail_overrun_d;
        end
    end

    // Read address is rd_cnt_q on the issue cycle, so rdata_q lines up with valid_q.
    always_ff @(posedge clk30) begin
        if (ram_we) begin
            mem[wr_cnt_q] <= hps_data;
        end
        rdata_q <= mem[rd_cnt_q];
    end

    assign core_ack        = core_ack_q;
    assign core_data_valid = valid_q;
    assign core_data       = data_en_q ? rdata_q : 16'h0000;
    assign hps_lba         = hps_lba_q;
    assign hps_req         = (state_q == StReq);
    assign busy            = (state_q != StIdle);
    assign fail_short      = fail_short_q;
    assign fail_overrun    = fail_overrun_q;

endmodule

// File: tb/tb_cd_sector_buffer.sv
// Scoreboard bench for cd_sector_buffer: stimulus pushes expected LBAs, acks and sector words;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_cd_sector_buffer;
    localparam int WPS  = 1176;
    localparam int PACE = 8;
    localparam int TMO  = 100;

    logic        clk30 = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] core_lba = '0;
    logic        core_req = 1'b0;
    logic        core_ack;
    logic        core_data_valid;
    logic [15:0] core_data;
    logic [31:0] hps_lba;
    logic        hps_req;
    logic        hps_ack = 1'b0;
    logic        hps_data_valid = 1'b0;
    logic [15:0] hps_data = '0;
    logic        busy;
    logic        fail_short;
    logic        fail_overrun;

    cd_sector_buffer #(
        .WORDS_PER_SECTOR(WPS),
        .PACE_CYCLES     (PACE),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk30          (clk30),
        .reset_n        (reset_n),
        .core_lba       (core_lba),
        .core_req       (core_req),
        .core_ack       (core_ack),
        .core_data_valid(core_data_valid),
        .core_data      (core_data),
        .hps_lba        (hps_lba),
        .hps_req        (hps_req),
        .hps_ack        (hps_ack),
        .hps_data_valid (hps_data_valid),
        .hps_data       (hps_data),
        .busy           (busy),
        .fail_short     (fail_short),
        .fail_overrun   (fail_overrun)
    );

    always #5 clk30 = ~clk30;

    int unsigned cyc = 0;
    always @(posedge clk30) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_data_q[$];
    logic [31:0] exp_lba_q[$];
    int          exp_ack_q[$];  // expected ack cycle, or -1 when only the ack itself is required

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard.
    logic        mon_prev_req = 1'b0;
    int unsigned mon_next_valid = 0;
    int          mon_exp_c;
    always @(negedge clk30) begin
        if (hps_req) begin
            check("hps_req_pulse", 32'(mon_prev_req), 32'd0);
            check("hps_req_expected", 32'(exp_lba_q.size() != 0), 32'd1);
            if (exp_lba_q.size() != 0) check("hps_lba", hps_lba, exp_lba_q.pop_front());
        end
        mon_prev_req = hps_req;
        if (core_ack) begin
            check("core_ack_expected", 32'(exp_ack_q.size() != 0), 32'd1);
            if (exp_ack_q.size() != 0) begin
                mon_exp_c = exp_ack_q.pop_front();
                if (mon_exp_c >= 0) check("core_ack_cycle", cyc, 32'(mon_exp_c));
            end
            mon_next_valid = cyc + PACE;
        end
        if (core_data_valid) begin
            check("valid_expected", 32'(exp_data_q.size() != 0), 32'd1);
            if (exp_data_q.size() != 0) check("core_data", 32'(core_data), 32'(exp_data_q.pop_front()));
            check("valid_cycle", cyc, mon_next_valid);
            mon_next_valid = cyc + PACE;
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_core_ack"}, 32'(core_ack), 32'd0);
        check({tag, "_core_data_valid"}, 32'(core_data_valid), 32'd0);
        check({tag, "_core_data"}, 32'(core_data), 32'd0);
        check({tag, "_hps_lba"}, hps_lba, 32'd0);
        check({tag, "_hps_req"}, 32'(hps_req), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_fail_short"}, 32'(fail_short), 32'd0);
        check({tag, "_fail_overrun"}, 32'(fail_overrun), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk30);
        #1 reset_n = 1'b0;
        hps_data_valid = 1'b0;
        hps_ack = 1'b0;
        core_req = 1'b0;
        #1 check_zero_outputs(tag);
        exp_data_q.delete();
        exp_ack_q.delete();
        exp_lba_q.delete();
        repeat (3) @(posedge clk30);
        #1 reset_n = 1'b1;
    endtask

    task automatic do_req(input logic [31:0] lba, input bit served);
        if (served) exp_lba_q.push_back(lba);
        @(posedge clk30);
        #1 core_lba = lba;
        core_req = 1'b1;
        @(posedge clk30);
        #1 core_req = 1'b0;
        core_lba = $urandom;
    endtask

    task automatic wait_hps_req(input int budget);
        int k = 0;
        while (hps_req !== 1'b1 && k < budget) begin
            @(negedge clk30);
            k++;
        end
        check("hps_req_seen", 32'(hps_req), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk30);
            k++;
        end
        check("idle_reached", 32'(busy), 32'd0);
        check("data_all_delivered", 32'(exp_data_q.size()), 32'd0);
        check("acks_all_seen", 32'(exp_ack_q.size()), 32'd0);
    endtask

    // HPS side: ack, then n words. Model: the first min(n, WPS) words are replayed, the rest of
    // the sector reads zero; a full sector acks one cycle after its last word.
    task automatic serve(input int n, input bit incr, input bit gaps);
        logic [15:0] sent[$];
        int fill;
        fill = (n < WPS) ? n : WPS;
        for (int i = 0; i < n; i++) sent.push_back(incr ? 16'(i) : 16'($urandom));
        for (int i = 0; i < WPS; i++) exp_data_q.push_back(i < fill ? sent[i] : 16'h0000);
        @(posedge clk30);
        #1 hps_ack = 1'b1;
        @(posedge clk30);
        #1 hps_ack = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    hps_data_valid = 1'b0;
                    @(posedge clk30);
                    #1;
                end
            end
            hps_data_valid = 1'b1;
            hps_data = sent[i];
            if (i == WPS - 1) exp_ack_q.push_back(int'(cyc) + 1);
            @(posedge clk30);
            #1;
        end
        hps_data_valid = 1'b0;
        hps_data = '0;
        if (n < WPS) exp_ack_q.push_back(-1);
    endtask

    initial begin
        #2 check_zero_outputs("reset");
        repeat (3) @(posedge clk30);
        #1 reset_n = 1'b1;

        // Nominal sector, incrementing data.
        do_req(32'h10, 1'b1);
        wait_hps_req(20);
        serve(WPS, 1'b1, 1'b0);
        wait_idle(12000);
        check("nominal_fail_short", 32'(fail_short), 32'd0);
        check("nominal_fail_overrun", 32'(fail_overrun), 32'd0);

        // Stray HPS word while idle.
        @(posedge clk30);
        #1 hps_data_valid = 1'b1;
        hps_data = 16'($urandom);
        @(posedge clk30);
        #1 hps_data_valid = 1'b0;
        repeat (20) @(posedge clk30);
        check("stray_fail_overrun", 32'(fail_overrun), 32'd1);
        check("stray_busy", 32'(busy), 32'd0);

        // Short transfer: 1000 words then silence.
        do_req($urandom, 1'b1);
        wait_hps_req(20);
        serve(1000, 1'b0, 1'b1);
        wait_idle(12000);
        check("short_fail_short", 32'(fail_short), 32'd1);

        // Reset in the middle of a fill; both sticky flags are set at this point.
        do_req($urandom, 1'b1);
        wait_hps_req(20);
        @(posedge clk30);
        #1 hps_ack = 1'b1;
        @(posedge clk30);
        #1 hps_ack = 1'b0;
        for (int i = 0; i < 500; i++) begin
            hps_data_valid = 1'b1;
            hps_data = 16'($urandom);
            @(posedge clk30);
            #1;
        end
        do_reset("midfill");

        // Clean sector after reset.
        do_req($urandom, 1'b1);
        wait_hps_req(20);
        serve(WPS, 1'b1, 1'b1);
        wait_idle(12000);
        check("post_reset_fail_short", 32'(fail_short), 32'd0);
        check("post_reset_fail_overrun", 32'(fail_overrun), 32'd0);

        // Overrun: four extra words.
        do_req($urandom, 1'b1);
        wait_hps_req(20);
        serve(WPS + 4, 1'b0, 1'b0);
        wait_idle(12000);
        check("overrun_fail_overrun", 32'(fail_overrun), 32'd1);
        check("overrun_fail_short", 32'(fail_short), 32'd0);

        // Pending request served after the current sector; a third request is dropped.
        do_reset("pre_pending");
        do_req($urandom, 1'b1);
        wait_hps_req(20);
        serve(WPS, 1'b0, 1'b1);
        repeat (50) @(posedge clk30);
        do_req(32'h20, 1'b1);
        repeat (5) @(posedge clk30);
        do_req(32'h33, 1'b0);
        wait_hps_req(12000);
        serve(WPS, 1'b0, 1'b1);
        wait_idle(12000);
        repeat (30) @(posedge clk30);
        check("pending_no_third_req", 32'(exp_lba_q.size()), 32'd0);
        check("pending_busy", 32'(busy), 32'd0);
        check("pending_fail_short", 32'(fail_short), 32'd0);
        check("pending_fail_overrun", 32'(fail_overrun), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
